// File: rtl/async_ctrl_pkg.sv
// Shared types and sizing helpers for
// handshake controllers around delay lines.
`timescale 1ns/1ps
package async_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    HOLD    = 2'd2,
    WAIT_LO = 2'd3
  } arb_state_t;

  localparam int TIMEOUT_MAX = 65535;

  // counter only ever holds 0..timeout-1
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

  localparam int CNT_W_MAX = cnt_width(TIMEOUT_MAX);

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous
// completion input.
`timescale 1ns/1ps
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // capture then re-time to settle metastability
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter sharing one matched
// delay line between four-phase requesters.
`timescale 1ns/1ps
module delay_arbiter
  import async_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     dly_in1,
  output logic                     dly_in2,
  input  logic                     dly_out,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = cnt_width(TIMEOUT);

  localparam logic [GW-1:0]    GID_RST  = GW'(N_REQ - 1);
  localparam logic [CW-1:0]    CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);

  arb_state_t       state, state_nx;
  logic [N_REQ-1:0] ack_q, ack_nx;
  logic [GW-1:0]    gid_q, gid_nx;
  logic             dly_q, dly_nx;
  logic             err_q, err_nx;
  logic [CW-1:0]    cnt_q, cnt_nx;
  logic             out_s;

  sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (dly_out),
    .q     (out_s)
  );

  // first set bit after the last grant, wrapping
  function automatic logic [GW-1:0] rr_pick(
    input logic [N_REQ-1:0] r,
    input logic [GW-1:0]    last
  );
    logic [GW-1:0] pick;
    int            idx;
    pick = last;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last) + i) % N_REQ;
      if (r[GW'(idx)]) pick = GW'(idx);
    end
    return pick;
  endfunction

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ack_q <= '0;
      gid_q <= GID_RST;
      dly_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state <= state_nx;
      ack_q <= ack_nx;
      gid_q <= gid_nx;
      dly_q <= dly_nx;
      err_q <= err_nx;
      cnt_q <= cnt_nx;
    end
  end

  // handshake sequencing and watchdog
  always_comb begin
    state_nx = state;
    ack_nx   = ack_q;
    gid_nx   = gid_q;
    dly_nx   = dly_q;
    err_nx   = err_q;
    cnt_nx   = cnt_q;
    unique case (state)
      IDLE: begin
        if (|req) begin
          gid_nx   = rr_pick(req, gid_q);
          dly_nx   = 1'b1;
          cnt_nx   = '0;
          state_nx = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (out_s) begin
          ack_nx   = ONE << gid_q;
          state_nx = HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_nx   = 1'b1;
          dly_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = WAIT_LO;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!req[gid_q]) begin
          dly_nx   = 1'b0;
          cnt_nx   = '0;
          state_nx = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!out_s) begin
          ack_nx   = '0;
          state_nx = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          err_nx   = 1'b1;
          ack_nx   = '0;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt_q + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign ack         = ack_q;
  assign grant_id    = gid_q;
  assign dly_in1     = dly_q;
  assign dly_in2     = dly_q;
  assign busy        = (state != IDLE);
  assign timeout_err = err_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// Randomized self-checking bench for
// delay_arbiter with a transport-delay line.
`timescale 1ns/1ps
module tb_delay_arbiter;

  localparam int N  = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = '0;
  logic [3:0] ack;
  logic [1:0] grant_id;
  logic       dly_in1, dly_in2;
  logic       dly_out;
  logic       busy, timeout_err;

  int checks = 0;
  int errors = 0;

  // delay line: 0 normal, 1 stuck low, 2 stuck high, 3 manual
  int   dly_ns    = 65;
  int   line_mode = 0;
  logic line_out  = 1'b0;
  logic man_out   = 1'b0;

  int last    = 3;
  bit err_exp = 1'b0;

  always #5 clk = ~clk;

  assign dly_out = (line_mode == 1) ? 1'b0 :
                   (line_mode == 2) ? 1'b1 :
                   (line_mode == 3) ? man_out : line_out;

  always @(dly_in1) begin
    automatic logic v = dly_in1;
    automatic int   d = dly_ns;
    fork
      begin
        #(d);
        line_out = v;
      end
    join_none
  end

  delay_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .ack         (ack),
    .grant_id    (grant_id),
    .dly_in1     (dly_in1),
    .dly_in2     (dly_in2),
    .dly_out     (dly_out),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int rr(input logic [3:0] r,
                            input int from);
    for (int i = 1; i <= N; i++)
      if (r[(from + i) % N]) return (from + i) % N;
    return from;
  endfunction

  // one full four-phase grant with latency checks
  task automatic txn(input  logic [3:0] pend,
                     input  int         hold,
                     input  bit         early,
                     input  logic [3:0] arr_hi,
                     input  logic [3:0] arr_lo,
                     output int         g);
    int         k;
    logic [3:0] oh;
    k   = (dly_ns - 5) / 10;
    req = pend;
    step();
    g  = rr(pend, last);
    oh = 4'b0001 << g;
    chk("grant", grant_id, g);
    chk("dly1_up", dly_in1, 1);
    chk("dly2_up", dly_in2, 1);
    chk("busy_up", busy, 1);
    chk("ack_idle", ack, 0);
    if (early) req[g] = 1'b0;
    req = req | (arr_hi & ~oh);
    step(k + 2);
    chk("ack_wait", ack, 0);
    chk("grant_wait", grant_id, g);
    step();
    chk("ack_rise", ack, oh);
    if (!early) begin
      step(hold);
      chk("dly_held", dly_in1, 1);
      req[g] = 1'b0;
    end
    step();
    chk("dly1_down", dly_in1, 0);
    chk("dly2_down", dly_in2, 0);
    chk("ack_flush", ack, oh);
    req = req | (arr_lo & ~oh);
    step(k + 2);
    chk("ack_lo_wait", ack, oh);
    chk("grant_lo", grant_id, g);
    step();
    chk("ack_fall", ack, 0);
    chk("busy_end", busy, 0);
    chk("err_state", timeout_err, err_exp);
    last = g;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int g, pg, k;
    logic [3:0] p;

    // reset values
    step(2);
    chk("rst_ack", ack, 0);
    chk("rst_gid", grant_id, 3);
    chk("rst_dly1", dly_in1, 0);
    chk("rst_dly2", dly_in2, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", timeout_err, 0);
    #3 rst_n = 1'b1;
    step();
    chk("idle_busy", busy, 0);
    chk("idle_gid", grant_id, 3);

    // fairness with all requests held
    pg = -1;
    for (int i = 0; i < 5; i++) begin
      txn(4'b1111, 0, 1'b0, 4'b0, 4'b0, g);
      chk("rr_order", g, i % N);
      if (i > 0) chk("no_repeat", g != pg, 1);
      pg = g;
    end

    // single requester, 65 ns line
    req = '0;
    step(2);
    dly_ns = 65;
    txn(4'b0001, 0, 1'b0, 4'b0, 4'b0, g);
    chk("single_gid", g, 0);

    // late request during WAIT_LO
    txn(4'b0001, 1, 1'b0, 4'b0, 4'b0010, g);
    txn(req, 0, 1'b0, 4'b0, 4'b0, g);
    chk("late_gid", g, 1);

    // glitch immunity while waiting for low
    req = '0;
    step(12);
    line_mode = 3;
    man_out   = 1'b0;
    req = 4'b0100;
    step();
    chk("gl_grant", grant_id, 2);
    man_out = 1'b1;
    step(3);
    chk("gl_ack", ack, 4'b0100);
    req = '0;
    step();
    chk("gl_flush", dly_in1, 0);
    #2 man_out = 1'b0;
    #4 man_out = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("gl_ignored", {busy, ack}, 5'b10100);
    end
    man_out = 1'b0;
    step();
    man_out = 1'b1;
    step();
    chk("gl_one_stage", ack, 4'b0100);
    step();
    chk("gl_pass_ack", ack, 0);
    chk("gl_pass_busy", busy, 0);
    last = 2;
    man_out   = 1'b0;
    step(12);
    line_mode = 0;

    // randomized traffic
    for (int it = 0; it < 30; it++) begin
      dly_ns = 10 * $urandom_range(2, 9) + 5;
      p = req | 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) p = 4'b0;
      if (p == 4'b0) begin
        req = '0;
        step();
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_dly", dly_in1, 0);
        chk("rnd_idle_gid", grant_id, last);
      end else begin
        txn(p, $urandom_range(0, 3),
            $urandom_range(0, 3) == 0,
            4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), g);
      end
    end

    // stuck-low line times out in WAIT_HI
    req = '0;
    step(12);
    line_mode = 1;
    req = 4'b0010;
    step();
    g = rr(4'b0010, last);
    chk("s0_grant", grant_id, g);
    step(TO - 1);
    chk("s0_pre_err", timeout_err, 0);
    chk("s0_pre_dly", dly_in1, 1);
    chk("s0_pre_ack", ack, 0);
    req = '0;
    step();
    chk("s0_err", timeout_err, 1);
    chk("s0_dly1", dly_in1, 0);
    chk("s0_dly2", dly_in2, 0);
    chk("s0_ack", ack, 0);
    step();
    chk("s0_idle", busy, 0);
    chk("s0_no_ack", ack, 0);
    err_exp = 1'b1;
    last = g;
    step(12);
    line_mode = 0;

    // stuck-high line times out in WAIT_LO
    dly_ns = 35;
    k = 3;
    req = 4'b1000;
    step();
    chk("s1_grant", grant_id, 3);
    step(k + 3);
    chk("s1_ack", ack, 4'b1000);
    line_mode = 2;
    req = '0;
    step();
    chk("s1_flush", dly_in1, 0);
    step(TO - 1);
    chk("s1_pre", {busy, ack}, 5'b11000);
    step();
    chk("s1_ack_clr", ack, 0);
    chk("s1_idle", busy, 0);
    chk("s1_err", timeout_err, 1);
    step(12);
    line_mode = 0;
    last = 3;

    // asynchronous reset in HOLD
    dly_ns = 45;
    req = 4'b0100;
    step();
    chk("rh_grant", grant_id, rr(4'b0100, last));
    step(7);
    chk("rh_ack", ack, 4'b0100);
    #3 rst_n = 1'b0;
    #1;
    chk("rh_ack0", ack, 0);
    chk("rh_dly1", dly_in1, 0);
    chk("rh_dly2", dly_in2, 0);
    chk("rh_busy", busy, 0);
    chk("rh_err", timeout_err, 0);
    chk("rh_gid", grant_id, 3);
    req = '0;
    #2 rst_n = 1'b1;
    err_exp = 1'b0;
    last = 3;
    step(12);
    txn(4'b0101, 0, 1'b0, 4'b0, 4'b0, g);
    chk("rh_scan0", g, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_arbiter.md
DELAY_ARBITER -- requirements
Module: delay_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing one matched-delay line (2..8).
REQ-002 Parameter TIMEOUT, default 255: maximum clk cycles to wait for a delay-line edge (1..65535).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  N_REQ  per-requester four-phase request, synchronous to clk.
REQ-006 ack  output  N_REQ  per-requester four-phase acknowledge, registered, one-hot or zero.
REQ-007 grant_id  output  $clog2(N_REQ)  index of the current or last granted requester.
REQ-008 dly_in1  output  1  drives delay-line data input, registered.
REQ-009 dly_in2  output  1  drives delay-line enable/flush input, registered, always equal to dly_in1.
REQ-010 dly_out  input  1  delay-line completion, asynchronous to clk.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 timeout_err  output  1  sticky error flag, cleared only by reset.

Function
REQ-013 dly_out SHALL pass through a 2-flop synchronizer; out_s denotes the second flop output, and all FSM decisions SHALL use out_s only.
REQ-014 States: IDLE, WAIT_HI, HOLD, WAIT_LO.
REQ-015 IDLE, any req bit high: select the first set bit scanning grant_id+1, grant_id+2, ... (mod N_REQ) and register it into grant_id; set dly_in1=dly_in2=1; go to WAIT_HI. All three updates take effect at the same edge.
REQ-016 IDLE, req all zero: hold every output.
REQ-017 WAIT_HI, out_s=1: set ack[grant_id]=1; go to HOLD.
REQ-018 HOLD, req[grant_id]=0: clear dly_in1 and dly_in2; go to WAIT_LO. ack stays high.
REQ-019 WAIT_LO, out_s=0: clear ack[grant_id]; go to IDLE. A new grant SHALL NOT issue earlier than the next edge.
REQ-020 A cycle counter SHALL clear on entry to WAIT_HI and to WAIT_LO, and SHALL increment each cycle spent in either state.
REQ-021 WAIT_HI, counter reaches TIMEOUT with out_s=0: set timeout_err; clear dly_in1 and dly_in2; go to WAIT_LO with no ack.
REQ-022 WAIT_LO, counter reaches TIMEOUT with out_s=1: set timeout_err; clear ack; go to IDLE.
REQ-023 Requests that arrive or drop while not in IDLE SHALL NOT affect the grant. Exception: a granted requester that drops req in WAIT_HI SHALL still receive ack. The four-phase rule then completes through HOLD immediately.
REQ-024 Reset values: ack=0, grant_id=N_REQ-1 so the first scan starts at 0, dly_in1=dly_in2=0, busy=0, timeout_err=0, counter=0, synchronizer flops=0, state=IDLE.
REQ-025 Minimum grant-to-grant latency equals the two delay-line propagations, plus 2 synchronizer cycles per edge, plus 4 FSM cycles.

Reset
REQ-026 Asserting rst_n low SHALL force all REQ-024 values immediately, without waiting for clk, including mid-transaction. The delay line is flushed by dly_in2=0.
REQ-027 Deassertion SHALL be synchronized externally. The first FSM transition SHALL occur on the first clk edge with rst_n high.

Structure
REQ-028 The FSM state enumeration and its encoding SHALL live in the shared package async_ctrl_pkg, together with the counter width constant derived from TIMEOUT.
REQ-029 The 2-flop synchronizer SHALL be a separate sub-module, sync2, reusable for other asynchronous completion inputs.
REQ-030 The round-robin select SHALL be a function or combinational block inside delay_arbiter, not a separate module.

Verification
REQ-031 Single requester: req=4'b0001, delay line modelled at 60 ns with 10 ns clk -> dly_in1 rises 1 cycle after req; ack[0] rises about 6+2 cycles later; req drop -> dly_in1 falls; ack[0] falls after the flush plus 2 cycles.
REQ-032 Fairness: req=4'b1111 held, each requester drops req on ack -> grant order 0,1,2,3,0; no requester granted twice in a row.
REQ-033 Stuck delay line: dly_out tied 0, TIMEOUT=20 -> after 20 WAIT_HI cycles, timeout_err=1, dly_in1=0, ack never rises, FSM reaches IDLE.
REQ-034 Reset mid-HOLD: ack[2]=1, assert rst_n=0 between clk edges -> ack=0 and dly_in1/in2=0 immediately; after release, next grant scans from 0.
REQ-035 Late request: req[1] rises while state=WAIT_LO for requester 0 -> no grant until IDLE; grant_id=1 one edge after IDLE is entered.
REQ-036 Glitch immunity: a 1-cycle dly_out pulse in WAIT_LO -> no state change unless it propagates through both synchronizer flops.
